// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and the SDRAM controller's
// Wishbone slave port.
//   master modport: drives cyc/stb/we/addr/dat_o/sel/cti, samples ack/dat_i
//   slave  modport: mirror image, used by the controller or a bus model
interface wb_burst_master_if #(
  parameter int AW = 26,
  parameter int DW = 32
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master feeding the SDRAM controller.
// Turns a command (start address, beat count, direction) into one Wishbone
// burst: cti 010 on non-final beats, 111 on the final beat, 000 for a
// single-beat command. Write data is pulled through a one-entry holding
// register; read data is pushed out one cycle after each ack with no
// backpressure. A watchdog aborts a burst stalled for TIMEOUT cycles.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   sdr_init_done             commands are held off until this is high
//   cmd_valid/cmd_ready       command handshake; cmd_we, cmd_addr, cmd_len
//                             (beats minus one) qualify it
//   wdata_valid/wdata_ready   write data stream, wdata
//   rdata_valid/rdata/rdata_last  read data stream, last beat flagged
//   done_o, err_o             end-of-burst pulse, error pulse on abort
//   wb                        Wishbone master port (wb_burst_master_if.master)
module wb_burst_master #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                sdr_init_done,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [AW-1:0]       cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [DW-1:0]       wdata,
  output logic                rdata_valid,
  output logic [DW-1:0]       rdata,
  output logic                rdata_last,
  output logic                done_o,
  output logic                err_o,
  wb_burst_master_if.master   wb
);

  localparam int         BYTES       = DW / 8;
  localparam int         WDW         = $clog2(TIMEOUT + 1);
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t         state, state_next;
  logic [AW-1:0]  addr;
  logic [7:0]     beats_left;   // acks still owed, minus one
  logic           single;       // command was a single beat
  logic [8:0]     fetch_left;   // write beats not yet pulled from the stream
  logic           hold_full;
  logic [DW-1:0]  hold_data;
  logic [WDW-1:0] wd_cnt;

  logic stb;
  logic ack;
  logic last_ack;
  logic wd_expire;
  logic cmd_fire;
  logic wdata_fire;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    cmd_ready  = 1'b0;
    stb        = 1'b0;
    unique case (state)
      IDLE: begin
        // Reset gates cmd_ready so nothing is accepted while reset is held.
        cmd_ready = sdr_init_done && !wb_rst_i;
        if (cmd_valid && cmd_ready) state_next = cmd_we ? WR : RD;
      end
      RD:      stb = 1'b1;
      WR:      stb = hold_full;  // strobe only while a beat is staged
      default: state_next = IDLE;
    endcase

    // An ack while stb is low belongs to nobody and is ignored.
    ack       = stb && wb.wb_ack_i;
    last_ack  = ack && (beats_left == 8'd0);
    wd_expire = stb && !wb.wb_ack_i && (wd_cnt == WDW'(TIMEOUT - 1));
    if (last_ack || wd_expire) state_next = IDLE;

    // The staged beat can be replaced in the same cycle it is acked, which
    // keeps back-to-back write beats stall-free.
    wdata_ready = (state == WR) && (!hold_full || ack) && (fetch_left != 9'd0);
  end

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign wdata_fire = wdata_valid && wdata_ready;

  // Bus outputs are decoded from registers only; cyc falls straight from the
  // asynchronous state reset.
  assign wb.wb_cyc_o  = (state != IDLE);
  assign wb.wb_stb_o  = stb;
  assign wb.wb_we_o   = (state == WR);
  assign wb.wb_addr_o = addr;
  assign wb.wb_dat_o  = hold_data;
  assign wb.wb_sel_o  = {BYTES{wb.wb_cyc_o}};
  // beats_left only moves on an ack, so cti holds through a write data gap.
  assign wb.wb_cti_o  = (state == IDLE || single) ? CTI_CLASSIC :
                        (beats_left == 8'd0)      ? CTI_END     : CTI_INCR;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      addr        <= '0;
      beats_left  <= '0;
      single      <= 1'b0;
      fetch_left  <= '0;
      hold_full   <= 1'b0;
      hold_data   <= '0;
      wd_cnt      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;

      if (cmd_fire) begin
        addr       <= cmd_addr;
        beats_left <= cmd_len;
        single     <= (cmd_len == 8'd0);
        fetch_left <= cmd_we ? (9'(cmd_len) + 9'd1) : 9'd0;
        hold_full  <= 1'b0;
      end

      // Address wraps modulo 2^AW by plain truncation.
      if (ack && !last_ack) begin
        addr       <= addr + AW'(BYTES);
        beats_left <= beats_left - 8'd1;
      end

      if (ack && state == RD) begin
        rdata       <= wb.wb_dat_i;
        rdata_valid <= 1'b1;
        rdata_last  <= last_ack;
      end

      if (wdata_fire) begin
        hold_data  <= wdata;
        hold_full  <= 1'b1;
        fetch_left <= fetch_left - 9'd1;
      end else if (ack) begin
        hold_full  <= 1'b0;
      end

      if (last_ack) done_o <= 1'b1;

      // Abort drops the staged beat; the stream side is not told.
      if (wd_expire) begin
        done_o    <= 1'b1;
        err_o     <= 1'b1;
        hold_full <= 1'b0;
      end

      if (!stb || ack || wd_expire) wd_cnt <= '0;
      else                          wd_cnt <= wd_cnt + WDW'(1);
    end
  end

endmodule
